// File: rtl/multi_clk_gen_if.sv
// Control/status bundle for multi_clk_gen: per-channel enables, divider writes,
// resync request, and the divided clock and tick outputs.
interface multi_clk_gen_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 27,
  parameter int CH_W  = 3
);
  logic [NCH-1:0]   en;
  logic             resync;
  logic             div_load;
  logic [CH_W-1:0]  div_ch;
  logic [CNT_W-1:0] div_val;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  modport master (
    output en, resync, div_load, div_ch, div_val,
    input  clk_out, tick
  );

  modport slave (
    input  en, resync, div_load, div_ch, div_val,
    output clk_out, tick
  );
endinterface

// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock/tick divider with a cleaned downstream reset.
// Outputs are registered (1 cycle after the deciding edge); no backpressure.
module multi_clk_gen #(
  parameter int NCH        = 2,
  parameter int CNT_W      = 27,
  parameter int HP_DEFAULT = 24999999,
  parameter int CH_W       = 3
) (
  input  logic               clk_osc,
  input  logic               RESET_n,
  multi_clk_gen_if.slave     bus,
  output logic               reset
);

  logic [1:0]       rst_sync_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] hp_q  [NCH];
  logic [CNT_W-1:0] hp_d  [NCH];
  logic [NCH-1:0]   clk_q, clk_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   ld_hit;

  // Set asynchronously, released through two flops so downstream logic
  // sees a clean synchronous deassertion.
  always_ff @(posedge clk_osc or negedge RESET_n) begin
    if (!RESET_n) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign reset = rst_sync_q[1];

  // Only existing channel indices can match, so out-of-range writes fall away.
  always_comb begin
    ld_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      ld_hit[i] = bus.div_load && (32'(bus.div_ch) == 32'(i));
    end
  end

  always_comb begin
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      hp_d[i]  = hp_q[i];
      if (ld_hit[i]) begin
        hp_d[i] = bus.div_val;
      end
      if (bus.resync || ld_hit[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (bus.en[i]) begin
        if (cnt_q[i] == hp_q[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_osc or negedge RESET_n) begin
    if (!RESET_n) begin
      clk_q  <= '0;
      tick_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        hp_q[i]  <= CNT_W'(HP_DEFAULT);
      end
    end else begin
      clk_q  <= clk_d;
      tick_q <= tick_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        hp_q[i]  <= hp_d[i];
      end
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;

endmodule
